// File: rtl/regblock_pkg.sv
// regblock_pkg: shared return-address op encodings and register source selects.
package regblock_pkg;
    typedef enum logic [1:0] {
        RA_NOP  = 2'b00,
        RA_LOAD = 2'b01,
        RA_PUSH = 2'b10,
        RA_POP  = 2'b11
    } ra_op_e;
    localparam logic [1:0] MARY_SRC_MEMVAL    = 2'b00;
    localparam logic [1:0] MARY_SRC_ALU       = 2'b01;
    localparam logic [1:0] MARY_SRC_SHELLEY   = 2'b10;
    localparam logic [1:0] MARY_SRC_IMM       = 2'b11;
    localparam logic [1:0] SHELLEY_SRC_MEMVAL = 2'b00;
    localparam logic [1:0] SHELLEY_SRC_IMM    = 2'b01;
    localparam logic [1:0] SHELLEY_SRC_MARY   = 2'b10;
    localparam logic [1:0] SHELLEY_SRC_ALU    = 2'b11;
endpackage

// File: rtl/ra_stack.sv
// ra_stack: circular return-address stack with top pointer, count and sticky
// overflow/underflow flags.
module ra_stack
    import regblock_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 op,
    input  logic [WIDTH-1:0]           push_data,
    input  logic [WIDTH-1:0]           load_data,
    input  logic                       clear_flags,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    top_q, top_d, ptr_inc, ptr_dec, wr_idx;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             push, load, pop, grow, wr_en;
    logic [WIDTH-1:0] wr_data;
    assign empty     = count_q == '0;
    assign full      = count_q == CW'(DEPTH);
    assign top       = empty ? '0 : mem_q[top_q];
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    // A load into an empty stack grows it exactly like a push of the load data.
    always_comb begin
        push    = op == RA_PUSH;
        load    = op == RA_LOAD;
        pop     = op == RA_POP;
        ptr_inc = (top_q == PW'(DEPTH-1)) ? '0 : top_q + PW'(1);
        ptr_dec = (top_q == '0) ? PW'(DEPTH-1) : top_q - PW'(1);
        grow    = push || (load && empty);
        wr_en   = grow || load;
        wr_idx  = grow ? ptr_inc : top_q;
        wr_data = push ? push_data : load_data;
        top_d   = grow ? ptr_inc : (pop && !empty) ? ptr_dec : top_q;
        count_d = (grow && !full) ? count_q + CW'(1) : (pop && !empty) ? count_q - CW'(1) : count_q;
        ovf_d   = (push && full) || (ovf_q && !clear_flags);
        unf_d   = (pop && empty) || (unf_q && !clear_flags);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_en) mem_q[wr_idx] <= wr_data;
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
endmodule

// File: rtl/reg_block_stack.sv
// reg_block_stack: mary/shelley/comp working registers with source muxes and a
// hardware return-address stack fed by pc+PC_INC.
module reg_block_stack
    import regblock_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int RA_DEPTH = 8,
    parameter int PC_INC   = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              memval,
    input  logic [WIDTH-1:0]              aluout,
    input  logic [WIDTH-1:0]              immediate,
    input  logic [WIDTH-1:0]              pc,
    input  logic                          mary_write,
    input  logic                          shelley_write,
    input  logic                          comp_write,
    input  logic [1:0]                    mary_src,
    input  logic [1:0]                    shelley_src,
    input  logic [1:0]                    ra_op,
    input  logic                          clear_flags,
    output logic [WIDTH-1:0]              mary_out,
    output logic [WIDTH-1:0]              shelley_out,
    output logic [WIDTH-1:0]              comp_out,
    output logic [WIDTH-1:0]              ra_out,
    output logic [$clog2(RA_DEPTH+1)-1:0] ra_count,
    output logic                          ra_empty,
    output logic                          ra_full,
    output logic                          ra_overflow,
    output logic                          ra_underflow
);
    logic [WIDTH-1:0] mary_q, mary_d, shelley_q, shelley_d, comp_q, comp_d;
    logic [WIDTH-1:0] ret_addr;
    assign ret_addr    = pc + WIDTH'(PC_INC);
    assign mary_out    = mary_q;
    assign shelley_out = shelley_q;
    assign comp_out    = comp_q;
    // Both muxes read the pre-edge register values, so src 10/10 swaps.
    always_comb begin
        mary_d    = !mary_write ? mary_q :
                    mary_src == MARY_SRC_MEMVAL  ? memval :
                    mary_src == MARY_SRC_ALU     ? aluout :
                    mary_src == MARY_SRC_SHELLEY ? shelley_q : immediate;
        shelley_d = !shelley_write ? shelley_q :
                    shelley_src == SHELLEY_SRC_MEMVAL ? memval :
                    shelley_src == SHELLEY_SRC_IMM    ? immediate :
                    shelley_src == SHELLEY_SRC_MARY   ? mary_q : aluout;
        comp_d    = comp_write ? aluout : comp_q;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mary_q    <= '0;
            shelley_q <= '0;
            comp_q    <= '0;
        end else begin
            mary_q    <= mary_d;
            shelley_q <= shelley_d;
            comp_q    <= comp_d;
        end
    end
    ra_stack #(.WIDTH(WIDTH), .DEPTH(RA_DEPTH)) u_ra_stack (
        .clock       (clock),
        .reset       (reset),
        .op          (ra_op),
        .push_data   (ret_addr),
        .load_data   (memval),
        .clear_flags (clear_flags),
        .top         (ra_out),
        .count       (ra_count),
        .empty       (ra_empty),
        .full        (ra_full),
        .overflow    (ra_overflow),
        .underflow   (ra_underflow)
    );
endmodule

// File: tb/tb_reg_block_stack.sv
// tb_reg_block_stack: directed scoreboard bench for reg_block_stack.
module tb_reg_block_stack;
    logic        clock = 0, reset = 1;
    logic [15:0] memval = 0, aluout = 0, immediate = 0, pc = 0;
    logic        mary_write = 0, shelley_write = 0, comp_write = 0, clear_flags = 0;
    logic [1:0]  mary_src = 0, shelley_src = 0, ra_op = 0;
    logic [15:0] mary_out, shelley_out, comp_out, ra_out;
    logic [3:0]  ra_count;
    logic        ra_empty, ra_full, ra_overflow, ra_underflow;
    int          checks = 0, failures = 0;

    typedef struct {int sel; logic [15:0] val; string tag;} exp_t;
    exp_t sb[$];

    reg_block_stack dut (
        .clock(clock), .reset(reset), .memval(memval), .aluout(aluout),
        .immediate(immediate), .pc(pc), .mary_write(mary_write),
        .shelley_write(shelley_write), .comp_write(comp_write),
        .mary_src(mary_src), .shelley_src(shelley_src), .ra_op(ra_op),
        .clear_flags(clear_flags), .mary_out(mary_out), .shelley_out(shelley_out),
        .comp_out(comp_out), .ra_out(ra_out), .ra_count(ra_count),
        .ra_empty(ra_empty), .ra_full(ra_full), .ra_overflow(ra_overflow),
        .ra_underflow(ra_underflow)
    );

    always #5 clock = ~clock;

    localparam int MARY = 0, SHEL = 1, COMP = 2, RA = 3, CNT = 4, EMP = 5, FUL = 6, OVF = 7, UNF = 8;

    function automatic logic [15:0] obs(int s);
        case (s)
            MARY:    return mary_out;
            SHEL:    return shelley_out;
            COMP:    return comp_out;
            RA:      return ra_out;
            CNT:     return {12'd0, ra_count};
            EMP:     return {15'd0, ra_empty};
            FUL:     return {15'd0, ra_full};
            OVF:     return {15'd0, ra_overflow};
            default: return {15'd0, ra_underflow};
        endcase
    endfunction

    task automatic expect_v(int sel, logic [15:0] val, string tag);
        exp_t e;
        e.sel = sel; e.val = val; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        logic [15:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            checks++;
            assert (o === e.val) else begin
                failures++;
                $error("FAIL %s got=%0d exp=%0d", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        check_now();
        mary_write = 0; shelley_write = 0; comp_write = 0; ra_op = 0; clear_flags = 0;
    endtask

    task automatic expect_reset(string tag);
        expect_v(MARY, 0, {tag, "_mary"}); expect_v(SHEL, 0, {tag, "_shel"});
        expect_v(COMP, 0, {tag, "_comp"}); expect_v(RA, 0, {tag, "_ra"});
        expect_v(CNT, 0, {tag, "_cnt"});   expect_v(EMP, 1, {tag, "_empty"});
        expect_v(FUL, 0, {tag, "_full"});  expect_v(OVF, 0, {tag, "_ovf"});
        expect_v(UNF, 0, {tag, "_unf"});
    endtask

    task automatic push(logic [15:0] p, logic [15:0] exp_ra, logic [15:0] exp_cnt, string tag);
        pc = p; ra_op = 2'b10;
        expect_v(RA, exp_ra, tag); expect_v(CNT, exp_cnt, {tag, "_cnt"});
        tick();
    endtask

    task automatic pop(logic [15:0] exp_ra, logic [15:0] exp_cnt, string tag);
        ra_op = 2'b11;
        expect_v(RA, exp_ra, tag); expect_v(CNT, exp_cnt, {tag, "_cnt"});
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        expect_reset("por");
        check_now();
        #3 reset = 0;
        memval = 100; aluout = 2863; immediate = 14;
        mary_write = 1; mary_src = 2'b00; expect_v(MARY, 100, "mary_memval"); tick();
        mary_write = 1; mary_src = 2'b01; expect_v(MARY, 2863, "mary_alu"); tick();
        mary_write = 1; mary_src = 2'b11; expect_v(MARY, 14, "mary_imm"); tick();
        shelley_write = 1; shelley_src = 2'b01; expect_v(SHEL, 14, "shel_imm"); tick();
        comp_write = 1; expect_v(COMP, 2863, "comp_alu"); expect_v(MARY, 14, "mary_hold"); tick();
        mary_write = 1; mary_src = 2'b00; expect_v(MARY, 100, "mary_reload"); tick();
        mary_write = 1; shelley_write = 1; mary_src = 2'b10; shelley_src = 2'b10;
        expect_v(MARY, 14, "swap_mary"); expect_v(SHEL, 100, "swap_shel"); tick();
        shelley_write = 1; shelley_src = 2'b10; expect_v(SHEL, 14, "shel_mary"); tick();
        shelley_write = 1; shelley_src = 2'b11; aluout = 5; expect_v(SHEL, 5, "shel_alu"); tick();
        push(44, 46, 1, "push44");
        push(60, 62, 2, "push60");
        mary_write = 1; mary_src = 2'b00;
        expect_v(MARY, 100, "mary_with_push");
        push(80, 82, 3, "push80");
        #2 reset = 1;
        #1;
        expect_reset("async");
        check_now();
        #3 reset = 0;
        push(44, 46, 1, "re_push44");
        push(60, 62, 2, "re_push60");
        push(80, 82, 3, "re_push80");
        pop(62, 2, "pop1");
        pop(46, 1, "pop2");
        expect_v(EMP, 1, "pop3_empty");
        pop(0, 0, "pop3");
        expect_v(UNF, 1, "underflow"); expect_v(EMP, 1, "unf_empty");
        pop(0, 0, "pop4");
        clear_flags = 1; expect_v(UNF, 0, "unf_clear"); tick();
        for (int i = 0; i < 9; i++) begin
            if (i == 7) begin
                expect_v(FUL, 1, "full8"); expect_v(OVF, 0, "no_ovf8");
            end
            push(16'(2 * i), 16'(2 * i + 2), 16'(i < 8 ? i + 1 : 8), $sformatf("fill%0d", i));
        end
        expect_v(FUL, 1, "full9"); expect_v(OVF, 1, "ovf9"); check_now();
        for (int i = 1; i <= 8; i++)
            pop(16'(i < 8 ? 18 - 2 * i : 0), 16'(8 - i), $sformatf("drain%0d", i));
        expect_v(OVF, 1, "ovf_sticky"); expect_v(EMP, 1, "drain_empty"); check_now();
        clear_flags = 1; expect_v(OVF, 0, "ovf_clear"); expect_v(UNF, 0, "unf_clr2"); tick();
        ra_op = 2'b11; expect_v(UNF, 1, "unf_set"); tick();
        ra_op = 2'b11; clear_flags = 1; expect_v(UNF, 1, "set_wins"); tick();
        clear_flags = 1; expect_v(UNF, 0, "unf_clr3"); tick();
        memval = 100; ra_op = 2'b01;
        expect_v(RA, 100, "load_empty"); expect_v(CNT, 1, "load_empty_cnt"); tick();
        memval = 7; ra_op = 2'b01;
        expect_v(RA, 7, "load_top"); expect_v(CNT, 1, "load_top_cnt"); tick();
        push(16'hFFFF, 16'h0001, 2, "push_wrap");
        pop(7, 1, "pop_restore");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
